// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and request payload for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 30;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // One captured memory-stage access.
    typedef struct packed {
        logic                 we;
        logic [LANES-1:0]     mask;
        logic [IDX_W-1:0]     idx;
        logic [WORD_W-1:0]    data;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the core (master) and the data-memory responder (slave).
// Optional access_err signal present when DMEM_ERR_EN is defined.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic                 request;
    logic                 we_re;
    logic [LANES-1:0]     mask;
    logic [WORD_W-1:0]    address;
    logic [WORD_W-1:0]    store_data;
    logic [WORD_W-1:0]    load_data;
    logic                 valid;
`ifdef DMEM_ERR_EN
    logic                 access_err;

    modport master (output request, we_re, mask, address, store_data,
                    input  load_data, valid, access_err);
    modport slave  (input  request, we_re, mask, address, store_data,
                    output load_data, valid, access_err);
`else
    modport master (output request, we_re, mask, address, store_data,
                    input  load_data, valid);
    modport slave  (input  request, we_re, mask, address, store_data,
                    output load_data, valid);
`endif

endinterface

// File: rtl/dmem_array.sv
// Byte-lane RAM: per-lane write enables, registered read data (cleared on non-read accesses).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              rd_i,
    input  logic [LANES-1:0]  we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [MEM_DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Lane-masked write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (we_i[l]) begin
                    mem_q[addr_i][l*BYTE_W +: BYTE_W] <= wdata_i[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read register: word on a load access, zero on stores and dropped accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= rd_i ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a memory-stage request, waits LATENCY-1 cycles,
// then performs the word access and pulses valid for one cycle.
// Define DMEM_ERR_EN to add access_err (out-of-range index or mask-less store).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        hold_q, hold_d;
    logic             valid_q, valid_d;
    dmem_req_t        acc_c;
    logic             enter_resp_c;
    logic             in_range_c;
    logic             unused_addr_c;

    // Byte offset is handled by the core-side wrapper.
    assign unused_addr_c = &{1'b0, bus.address[1:0]};

    // Live inputs while idle (LATENCY = 1 accesses on the accepting edge), captured copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_c.we   = bus.we_re;
            acc_c.mask = bus.mask;
            acc_c.idx  = bus.address[WORD_W-1:2];
            acc_c.data = bus.store_data;
        end else begin
            acc_c = hold_q;
        end
        in_range_c = (acc_c.idx < IDX_W'(MEM_DEPTH));
    end

    // Next-state, counter and capture logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        enter_resp_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.request) begin
                    hold_d = acc_c;
                    cnt_d  = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d      = ST_RESP;
                        enter_resp_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_RESP;
                    enter_resp_c = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        valid_d = enter_resp_c;
    end

    // State and holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign bus.valid = valid_q;

    dmem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (enter_resp_c & ~rst),
        .rd_i    (~acc_c.we & in_range_c),
        .we_i    ((acc_c.we & in_range_c) ? acc_c.mask : LANES'(0)),
        .addr_i  (acc_c.idx[AW-1:0]),
        .wdata_i (acc_c.data),
        .rdata_o (bus.load_data)
    );

`ifdef DMEM_ERR_EN
    logic err_q, err_d;

    assign err_d = enter_resp_c &
                   (~in_range_c | (acc_c.we & (acc_c.mask == LANES'(0))));

    // Error flag aligned with the valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.access_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (MEM_DEPTH = 1024, LATENCY = 2).
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_responder_if bus ();

    dmem_responder #(
        .MEM_DEPTH (1024),
        .LATENCY   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access from IDLE; returns edges-to-valid (0 on timeout), data, err and valid one edge later.
    task automatic access(input logic we, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat,
                          output logic err, output logic post_v);
        bus.request    = 1'b1;
        bus.we_re      = we;
        bus.mask       = m;
        bus.address    = a;
        bus.store_data = d;
        lat = 0;
        rd  = '0;
        err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = i;
                rd  = bus.load_data;
`ifdef DMEM_ERR_EN
                err = bus.access_err;
`endif
                break;
            end
        end
        bus.request = 1'b0;
        @(posedge clk); #1;
        post_v = bus.valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.request = 1'b0; bus.we_re = 1'b0; bus.mask = '0;
        bus.address = '0;   bus.store_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        total++; if (bus.load_data !== 32'h0) begin bad++; $display("FAIL reset_load_data got=%h exp=0", bus.load_data); end
`ifdef DMEM_ERR_EN
        total++; if (bus.access_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.access_err); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [31:0] rd; int lat; logic err; logic pv;
        access(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, rd, lat, err, pv);
        total++; if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d exp=2", lat); end
        total++; if (pv !== 1'b0) begin bad++; $display("FAIL store_valid_pulse got=%b exp=0", pv); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_load_data got=%h exp=0", rd); end
        access(1'b0, 4'h0, 32'h40, 32'h0, rd, lat, err, pv);
        total++; if (lat !== 2) begin bad++; $display("FAIL load_latency got=%0d exp=2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_40 got=%h exp=deadbeef", rd); end
        total++; if (pv !== 1'b0) begin bad++; $display("FAIL load_valid_pulse got=%b exp=0", pv); end
        access(1'b0, 4'h0, 32'h43, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_43_offset got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_masked();
        logic [31:0] rd; int lat; logic err; logic pv;
        access(1'b1, 4'hF, 32'h80, 32'h11223344, rd, lat, err, pv);
        access(1'b1, 4'b0100, 32'h80, 32'hAABBCCDD, rd, lat, err, pv);
        access(1'b0, 4'h0, 32'h80, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h11BB3344) begin bad++; $display("FAIL mask_0100 got=%h exp=11bb3344", rd); end
        access(1'b1, 4'b0011, 32'h80, 32'h0000EEFF, rd, lat, err, pv);
        access(1'b0, 4'h0, 32'h80, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h11BBEEFF) begin bad++; $display("FAIL mask_0011 got=%h exp=11bbeeff", rd); end
        access(1'b1, 4'b0000, 32'h80, 32'hFFFFFFFF, rd, lat, err, pv);
        total++; if (lat !== 2) begin bad++; $display("FAIL mask0_latency got=%0d exp=2", lat); end
`ifdef DMEM_ERR_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mask0_err got=%b exp=1", err); end
`endif
        access(1'b0, 4'h0, 32'h80, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h11BBEEFF) begin bad++; $display("FAIL mask0_nochange got=%h exp=11bbeeff", rd); end
`ifdef DMEM_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL inrange_load_err got=%b exp=0", err); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; logic err; logic pv;
        logic [4:0]  vp;
        logic [31:0] d1, d2;
        access(1'b1, 4'hF, 32'h200, 32'hA5A5A5A5, rd, lat, err, pv);
        access(1'b1, 4'hF, 32'h204, 32'h5A5A5A5A, rd, lat, err, pv);
        vp = '0; d1 = '0; d2 = '0;
        bus.request = 1'b1; bus.we_re = 1'b0; bus.address = 32'h200;
        // edge1 accept, edge2 RESP, edge3 IDLE bubble, edge4 accept, edge5 RESP
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            vp[i-1] = bus.valid;
            if (i == 2) begin d1 = bus.load_data; bus.address = 32'h204; end
            if (i == 5) begin d2 = bus.load_data; bus.request = 1'b0; end
        end
        @(posedge clk); #1;
        total++; if (vp !== 5'b10010) begin bad++; $display("FAIL b2b_valid_pattern got=%b exp=10010", vp); end
        total++; if (d1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL b2b_first got=%h exp=a5a5a5a5", d1); end
        total++; if (d2 !== 32'h5A5A5A5A) begin bad++; $display("FAIL b2b_second got=%h exp=5a5a5a5a", d2); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat; logic err; logic pv;
        access(1'b1, 4'hF, 32'h0, 32'h12345678, rd, lat, err, pv);
        access(1'b0, 4'h0, 32'h80, 32'h0, rd, lat, err, pv);
        access(1'b0, 4'h0, 32'h1000, 32'h0, rd, lat, err, pv);
        total++; if (lat !== 2) begin bad++; $display("FAIL oor_load_latency got=%0d exp=2", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_load_data got=%h exp=0", rd); end
`ifdef DMEM_ERR_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_load_err got=%b exp=1", err); end
`endif
        access(1'b1, 4'hF, 32'h1000, 32'h55555555, rd, lat, err, pv);
        total++; if (lat !== 2) begin bad++; $display("FAIL oor_store_latency got=%0d exp=2", lat); end
`ifdef DMEM_ERR_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_store_err got=%b exp=1", err); end
`endif
        access(1'b0, 4'h0, 32'h0, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL oor_store_alias got=%h exp=12345678", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic err; logic pv;
        access(1'b1, 4'hF, 32'h10, 32'h01020304, rd, lat, err, pv);
        access(1'b0, 4'h0, 32'h10, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL pre_reset_load got=%h exp=01020304", rd); end
        bus.request = 1'b1; bus.we_re = 1'b1; bus.mask = 4'hF;
        bus.address = 32'h10; bus.store_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", bus.valid); end
        total++; if (bus.load_data !== 32'h0) begin bad++; $display("FAIL midreset_load_data got=%h exp=0", bus.load_data); end
        bus.request = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 4'h0, 32'h10, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL midreset_store_abandoned got=%h exp=01020304", rd); end
    endtask

    task automatic test_churn();
        logic [31:0] rd; int lat; logic err; logic pv;
        access(1'b1, 4'hF, 32'h100, 32'h0BADBEEF, rd, lat, err, pv);
        bus.request = 1'b1; bus.we_re = 1'b1; bus.mask = 4'hF;
        bus.address = 32'hC0; bus.store_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.address = 32'h100; bus.store_data = 32'h00000000; bus.mask = 4'h0; bus.we_re = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL churn_valid got=%b exp=1", bus.valid); end
        bus.request = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 4'h0, 32'hC0, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL churn_captured got=%h exp=cafef00d", rd); end
        access(1'b0, 4'h0, 32'h100, 32'h0, rd, lat, err, pv);
        total++; if (rd !== 32'h0BADBEEF) begin bad++; $display("FAIL churn_other got=%h exp=0badbeef", rd); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_latency();
        test_masked();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_churn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
